// File: rtl/ysyx_23060191_lsu.sv
// ysyx_23060191_lsu: one-at-a-time load/store unit between EXU and write-back,
// with store lane formation, load extraction/extension and misalignment detection.
module ysyx_23060191_lsu #(
  parameter int CPU_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CPU_WIDTH-1:0] exu_res,
  input  logic [CPU_WIDTH-1:0] data_Rs2,
  input  logic [3:0]           lsu_opt,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [CPU_WIDTH-1:0] mem_addr,
  output logic                 mem_wen,
  output logic [CPU_WIDTH-1:0] mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic                 mem_rsp_valid,
  input  logic [CPU_WIDTH-1:0] mem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] lsu_res,
  output logic                 lsu_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t               state_q;
  logic [3:0]           opt_q;
  logic [1:0]           off_q;
  logic [CPU_WIDTH-1:0] addr_q, wdata_q, res_q;
  logic                 wen_q, err_q;
  logic [3:0]           wmask_q;
  logic [3:0]           opt;
  logic                 mis;
  logic [CPU_WIDTH-1:0] wdata_d, sh, ld;
  logic [3:0]           wmask_d;
  // Undefined opcodes collapse to NONE so they pass exu_res straight through.
  assign opt = (lsu_opt inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h9, 4'hA, 4'hB}) ? lsu_opt : 4'h0;
  assign mis = ((opt == 4'h2 || opt == 4'h5 || opt == 4'hA) && exu_res[0]) ||
               ((opt == 4'h3 || opt == 4'hB) && exu_res[1:0] != 2'b00);
  assign wdata_d = opt == 4'h9 ? {(CPU_WIDTH/8){data_Rs2[7:0]}} :
                   opt == 4'hA ? {(CPU_WIDTH/16){data_Rs2[15:0]}} : data_Rs2;
  assign wmask_d = opt == 4'h9 ? 4'b0001 << exu_res[1:0] :
                   opt == 4'hA ? 4'b0011 << exu_res[1:0] :
                   opt == 4'hB ? 4'b1111 : 4'b0000;
  assign sh = mem_rdata >> {off_q, 3'b000};
  assign ld = opt_q == 4'h1 ? {{(CPU_WIDTH-8){sh[7]}}, sh[7:0]} :
              opt_q == 4'h2 ? {{(CPU_WIDTH-16){sh[15]}}, sh[15:0]} :
              opt_q == 4'h4 ? {{(CPU_WIDTH-8){1'b0}}, sh[7:0]} :
              opt_q == 4'h5 ? {{(CPU_WIDTH-16){1'b0}}, sh[15:0]} : sh;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opt_q   <= 4'h0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 4'b0000;
      wen_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          opt_q   <= opt;
          off_q   <= exu_res[1:0];
          addr_q  <= {exu_res[CPU_WIDTH-1:2], 2'b00};
          wen_q   <= opt[3];
          wdata_q <= wdata_d;
          wmask_q <= wmask_d;
          err_q   <= mis;
          res_q   <= opt == 4'h0 ? exu_res : '0;
          state_q <= (opt == 4'h0 || mis) ? DONE : REQ;
        end
        REQ: if (mem_req_ready) state_q <= WAIT;
        WAIT: if (mem_rsp_valid) begin
          res_q   <= opt_q[3] ? '0 : ld;
          state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready      = state_q == IDLE;
  assign mem_req_valid = state_q == REQ;
  assign out_valid     = state_q == DONE;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign lsu_res       = res_q;
  assign lsu_err       = err_q;
endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
// tb_ysyx_23060191_lsu: directed vector table plus hand-written backpressure
// and mid-transaction reset sequences for the load/store unit.
module tb_ysyx_23060191_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] exu_res = '0, data_Rs2 = '0;
  logic [3:0]  lsu_opt = '0;
  logic        mem_req_valid, mem_req_ready = 1'b1;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] lsu_res;
  logic        lsu_err;
  int checks = 0, errors = 0;

  ysyx_23060191_lsu #(.CPU_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .exu_res(exu_res), .data_Rs2(data_Rs2), .lsu_opt(lsu_opt),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .lsu_res(lsu_res), .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  opt;
    logic [31:0] addr, rs2, rdata;
    logic        req;
    logic [31:0] maddr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge clk);
    chk($sformatf("v%0d_in_ready", i), in_ready, 1);
    lsu_opt = v.opt; exu_res = v.addr; data_Rs2 = v.rs2; mem_rdata = v.rdata; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("v%0d_req_valid", i), mem_req_valid, v.req);
    if (v.req) begin
      chk($sformatf("v%0d_addr", i), mem_addr, v.maddr);
      chk($sformatf("v%0d_wen", i), mem_wen, v.wen);
      chk($sformatf("v%0d_wmask", i), mem_wmask, v.wmask);
      if (v.wen) chk($sformatf("v%0d_wdata", i), mem_wdata, v.wdata);
      @(negedge clk);
      chk($sformatf("v%0d_wait_out_valid", i), out_valid, 0);
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    chk($sformatf("v%0d_out_valid", i), out_valid, 1);
    chk($sformatf("v%0d_res", i), lsu_res, v.res);
    chk($sformatf("v%0d_err", i), lsu_err, v.err);
  endtask

  initial begin
    //           opt    addr          rs2           rdata         req   maddr         wen   wdata         wmask    res           err
    vecs[0]  = '{4'h0, 32'h1234_5678, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h1234_5678, 1'b0};
    vecs[1]  = '{4'h1, 32'h8000_0003, 32'h0,        32'h80AA_BBCC, 1'b1, 32'h8000_0000, 1'b0, 32'h0,      4'b0000, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{4'h4, 32'h8000_0003, 32'h0,        32'h80AA_BBCC, 1'b1, 32'h8000_0000, 1'b0, 32'h0,      4'b0000, 32'h0000_0080, 1'b0};
    vecs[3]  = '{4'hA, 32'h0100_0002, 32'hDEAD_BEEF, 32'h0,       1'b1, 32'h0100_0000, 1'b1, 32'hBEEF_BEEF, 4'b1100, 32'h0,        1'b0};
    vecs[4]  = '{4'h3, 32'h0000_0006, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[5]  = '{4'h2, 32'h1000_0002, 32'h0,        32'h8001_1234, 1'b1, 32'h1000_0000, 1'b0, 32'h0,      4'b0000, 32'hFFFF_8001, 1'b0};
    vecs[6]  = '{4'h5, 32'h1000_0000, 32'h0,        32'h8001_F234, 1'b1, 32'h1000_0000, 1'b0, 32'h0,      4'b0000, 32'h0000_F234, 1'b0};
    vecs[7]  = '{4'h3, 32'h2000_0004, 32'h0,        32'hCAFE_BABE, 1'b1, 32'h2000_0004, 1'b0, 32'h0,      4'b0000, 32'hCAFE_BABE, 1'b0};
    vecs[8]  = '{4'h9, 32'h0000_3001, 32'h1234_56A5, 32'h0,       1'b1, 32'h0000_3000, 1'b1, 32'hA5A5_A5A5, 4'b0010, 32'h0,        1'b0};
    vecs[9]  = '{4'hB, 32'h0000_4000, 32'h1122_3344, 32'h0,       1'b1, 32'h0000_4000, 1'b1, 32'h1122_3344, 4'b1111, 32'h0,        1'b0};
    vecs[10] = '{4'hA, 32'h0000_0005, 32'h1,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[11] = '{4'h7, 32'hABCD_0001, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'hABCD_0001, 1'b0};
    vecs[12] = '{4'h5, 32'h0000_0003, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        4'b0000, 32'h0,        1'b1};
    vecs[13] = '{4'h1, 32'h0000_0001, 32'h0,        32'h0000_7F00, 1'b1, 32'h0000_0000, 1'b0, 32'h0,      4'b0000, 32'h0000_007F, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_res", lsu_res, 0);
    chk("rst_err", lsu_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // LW with request backpressure, then write-back backpressure
    @(negedge clk);
    lsu_opt = 4'h3; exu_res = 32'h0000_0008; mem_rdata = 32'h55AA_55AA; in_valid = 1'b1; mem_req_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_req_valid%0d", k), mem_req_valid, 1);
      chk($sformatf("bp_addr%0d", k), mem_addr, 32'h8);
      @(negedge clk);
    end
    chk("bp_req_valid3", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_wait_req", mem_req_valid, 0);
    mem_rsp_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_out_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_res%0d", k), lsu_res, 32'h55AA_55AA);
      chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // reset asserted while waiting for the response
    lsu_opt = 4'h3; exu_res = 32'h0000_000C; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rmo_req_valid", mem_req_valid, 1);
    @(negedge clk);
    chk("rmo_in_wait", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rmo_req_valid_rst", mem_req_valid, 0);
    chk("rmo_out_valid_rst", out_valid, 0);
    chk("rmo_err_rst", lsu_err, 0);
    chk("rmo_in_ready_rst", in_ready, 1);
    chk("rmo_addr_rst", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rmo_stale_out_valid%0d", k), out_valid, 0);
      chk($sformatf("rmo_stale_in_ready%0d", k), in_ready, 1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060191_lsu.md
# ysyx_23060191_lsu

Load/store unit sitting directly downstream of the execute unit. It takes the EXU result as an effective address (or as a pass-through result for non-memory instructions) plus the rs2 value as store data. It runs one transaction at a time over a valid/ready memory port, aligns and masks store data, extracts and sign/zero-extends load data, flags misaligned accesses, and presents one registered result to write-back under a valid/ready handshake.

## Interface
- `CPU_WIDTH`, default 32: datapath width; all address and data ports use it.
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: EXU stage presents an instruction.
- `in_ready` out, 1: LSU can accept; equals (state == IDLE).
- `exu_res` in, CPU_WIDTH: effective address, or final result for non-memory ops.
- `data_Rs2` in, CPU_WIDTH: store data.
- `lsu_opt` in, 4: operation code.
  - 0x0 NONE, 0x1 LB, 0x2 LH, 0x3 LW, 0x4 LBU, 0x5 LHU, 0x9 SB, 0xA SH, 0xB SW.
  - Any other code behaves as NONE.
- `mem_req_valid` out, 1: memory request valid.
- `mem_req_ready` in, 1: memory accepts the request.
- `mem_addr` out, CPU_WIDTH: word-aligned address {addr[31:2], 2'b00}.
- `mem_wen` out, 1: 1 = store, 0 = load.
- `mem_wdata` out, CPU_WIDTH: lane-replicated store data.
- `mem_wmask` out, 4: byte enables for stores; 0 for loads.
- `mem_rsp_valid` in, 1: response for the outstanding request, for both loads and stores.
- `mem_rdata` in, CPU_WIDTH: load word.
- `out_valid` out, 1: result valid to write-back.
- `out_ready` in, 1: write-back accepts.
- `lsu_res` out, CPU_WIDTH: load value, pass-through value, or 0 for stores and errors.
- `lsu_err` out, 1: misaligned access; qualified by `out_valid`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**, on `in_valid`:
  - Latch `exu_res`, `data_Rs2` and `lsu_opt`.
  - NONE: `lsu_res` <= `exu_res`, go to DONE.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): `lsu_res` <= 0, `lsu_err` <= 1, go to DONE. No memory request is issued.
  - Otherwise: go to REQ.
- **REQ**:
  - `mem_req_valid`=1; `mem_addr`, `mem_wen`, `mem_wdata` and `mem_wmask` are driven from registers and stay stable.
  - Go to WAIT on the cycle `mem_req_ready`=1.
- **WAIT**:
  - On `mem_rsp_valid`, capture the result and go to DONE.
  - `mem_rsp_valid` is ignored in every other state.
- **DONE**: `out_valid`=1 and outputs held stable until `out_ready`=1, then go to IDLE.
- Store lane formation, with o = addr[1:0]:
  - SB: wdata={4{rs2[7:0]}}, wmask=4'b0001<<o.
  - SH: wdata={2{rs2[15:0]}}, wmask=4'b0011<<o.
  - SW: wdata=rs2, wmask=4'b1111.
- Load extraction: sh = `mem_rdata` >> (8*o).
  - LB/LH: sign-extend sh[7:0] / sh[15:0].
  - LBU/LHU: zero-extend sh[7:0] / sh[15:0].
  - LW: sh.
- Stores: `lsu_res`=0 after their response.

## Timing
- Reset values: state IDLE, `in_ready`=1, `mem_req_valid`=0, `mem_wen`=0, `mem_wmask`=0, `mem_addr`=0, `mem_wdata`=0, `out_valid`=0, `lsu_res`=0, `lsu_err`=0.
- Reset asserted mid-transaction:
  - All outputs take their reset values immediately (asynchronously).
  - The outstanding transaction is abandoned.
  - A late `mem_rsp_valid` arriving in IDLE is ignored.
- In the cycle numbering below, accept = cycle 0.
- NONE or misaligned: `out_valid` at cycle 1.
- Memory op:
  - `mem_req_valid` at cycle 1.
  - With `mem_req_ready`=1 at cycle 1 and `mem_rsp_valid` at cycle 2, `out_valid` is at cycle 3. This is the minimum latency.
- `mem_req_ready` may already be high when `mem_req_valid` rises; the handshake completes in that same cycle.
- A response is never expected in the same cycle as the request handshake. Responses are sampled only in WAIT.
- `out_ready` held low: DONE holds and `in_ready` stays 0. Back-to-back throughput is one instruction per (latency+1) cycles.
- `lsu_err` and `lsu_res` are valid only while `out_valid`=1.

## Test plan
- **NONE pass-through:** `lsu_opt`=0, `exu_res`=0x1234_5678, `out_ready`=1 → `out_valid` at cycle 1, `lsu_res`=0x1234_5678, no `mem_req_valid`.
- **Sign-extended byte load:** LB at addr 0x8000_0003, `mem_rdata`=0x80AA_BBCC, zero-wait memory → `mem_addr`=0x8000_0000, `mem_wmask`=0, `lsu_res`=0xFFFF_FF80 at cycle 3. Repeat with LBU → 0x0000_0080.
- **Halfword store:** SH at addr 0x100_0002, `data_Rs2`=0xDEAD_BEEF → `mem_wdata`=0xBEEF_BEEF, `mem_wmask`=4'b1100, `mem_wen`=1, `lsu_res`=0.
- **Backpressure:** `mem_req_ready` low for 3 cycles on an LW → `mem_req_valid` and `mem_addr` stable throughout. Then hold `out_ready` low for 4 cycles → `out_valid` and `lsu_res` stable, `in_ready`=0.
- **Misaligned:** LW at 0x0000_0006 → no memory request, `out_valid` at cycle 1, `lsu_err`=1, `lsu_res`=0.
- **Reset mid-op:** drop `rst_n` while in WAIT → `mem_req_valid`, `out_valid` and `lsu_err` go to 0 immediately, `in_ready`=1. A stale `mem_rsp_valid` after reset release produces no `out_valid`.
